// File: rtl/fp_accum_sequencer.sv
// Reduces LENGTH FP32 operands plus a bias through one shared combinational adder.
// Latency: out_valid one cycle after the last accepted operand (one cycle after start if length==0).
// Backpressure: one operand per cycle while summing; the result is held in OUTPUT until out_ready.
module fp_accum_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int E           = 8,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0]  bias,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  add_a,
  output logic [DATA_WIDTH-1:0]  add_b,
  input  logic [DATA_WIDTH-1:0]  add_sum,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   in_zero;
  logic                   acc_zero;
  logic                   last;

  // The adder assumes a hidden 1, so a zero exponent (zero or denormal) must bypass it.
  assign in_zero  = (in_data[DATA_WIDTH-2 -: E] == '0);
  assign acc_zero = (acc_q[DATA_WIDTH-2 -: E] == '0);
  // len_q is at least 1 whenever ACCUM is active, so the subtraction never wraps there.
  assign last     = (cnt_q == len_q - COUNT_WIDTH'(1));

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_data  = acc_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Next-state, accumulator update and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          len_d   = length;
          cnt_d   = '0;
          state_d = (length == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (!in_zero) begin
            acc_d = acc_zero ? in_data : add_sum;
          end
          cnt_d = cnt_q + COUNT_WIDTH'(1);
          if (last) begin
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == OUTPUT);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any reduction in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// Bench for fp_accum_sequencer: directed cases plus random reductions against a reference sum.
module tb_fp_accum_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  length = '0;
  logic [31:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] add_a, add_b, add_sum;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ops [0:63];

  fp_accum_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .length(length), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit is_zero(input logic [31:0] v);
    return v[30:23] == 8'd0;
  endfunction

  function automatic real f2r(input logic [31:0] a);
    logic [63:0] b;
    int de;
    de = int'(a[30:23]) - 127 + 1023;
    b = {a[31], de[10:0], a[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    b = $realtobits(r);
    if (r == 0.0) return {b[63], 31'd0};
    e = int'(b[62:52]) - 1023 + 127;
    if (e <= 0) return {b[63], 31'd0};
    if (e >= 255) return {b[63], 8'hff, 23'd0};
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Stand-in adder; it cannot handle zero operands, so it answers with a marker value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (is_zero(a) || is_zero(b)) return 32'h7fbadbad;
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb add_sum = fadd(add_a, add_b);

  // One reduction step: zero operands are skipped, a zero running sum takes the operand.
  function automatic logic [31:0] step(input logic [31:0] acc, input logic [31:0] op);
    if (is_zero(op)) return acc;
    if (is_zero(acc)) return op;
    return fadd(acc, op);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 4) == 0) v[30:23] = 8'd0;
    else v[30:23] = 8'($urandom_range(120, 134));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full reduction of ops[0:len-1] from bias b; gaps = max idle cycles between operands,
  // hold = cycles with out_ready low, poke = pulse start with another length mid-run.
  task automatic run(input int len, input logic [31:0] b, input int gaps, input int hold,
                     input bit poke);
    logic [31:0] acc_m;
    int g;
    acc_m = b;
    @(negedge clk);
    start = 1'b1; length = len[9:0]; bias = b;
    in_valid = 1'b1; in_data = 32'h3f800000;
    @(negedge clk);
    start = 1'b0; length = 10'($urandom); bias = $urandom; in_valid = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < len; i++) begin
      g = (gaps > 0) ? $urandom_range(0, gaps) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0; in_data = $urandom;
        chk("ready_in_gap", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
      end
      if (poke && i == 1) begin
        start = 1'b1; length = 10'd7; bias = 32'h42000000;
      end
      in_valid = 1'b1; in_data = ops[i];
      #1;
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      chk("add_a", add_a, acc_m);
      chk("add_b", add_b, ops[i]);
      acc_m = step(acc_m, ops[i]);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", out_data, acc_m);
    chk("ready_in_output", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("out_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("out_data_hold", out_data, acc_m);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("acc_held", out_data, acc_m);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    reset = 1'b0;

    // 5.25 + 20.7
    ops[0] = 32'h41a5999a;
    run(1, 32'h40a80000, 0, 0, 1'b0);
    chk("plan1_sum", out_data, 32'h41cf999a);

    // Zero bias takes the first operand directly
    for (int i = 0; i < 3; i++) ops[i] = 32'h3f800000;
    run(3, 32'h00000000, 0, 0, 1'b0);
    chk("plan2_sum", out_data, 32'h40400000);

    // Zero length goes straight to OUTPUT with the bias
    run(0, 32'h3f800000, 0, 1, 1'b0);
    chk("plan3_sum", out_data, 32'h3f800000);

    // Gaps, a zero operand and a stalled consumer
    ops[0] = 32'h3f800000; ops[1] = 32'h00000000; ops[2] = 32'h40000000; ops[3] = 32'h40400000;
    run(4, 32'h3f800000, 3, 5, 1'b0);
    chk("plan4_sum", out_data, 32'h40e00000);

    // Stray start while summing is ignored
    for (int i = 0; i < 3; i++) ops[i] = 32'h40000000;
    run(3, 32'h3f800000, 1, 0, 1'b1);
    chk("plan5_sum", out_data, 32'h40e00000);

    // Cancellation to exact zero, then the next operand bypasses the adder
    ops[0] = 32'hc0000000; ops[1] = 32'h3fc00000;
    run(2, 32'h40000000, 0, 0, 1'b0);
    chk("cancel_sum", out_data, 32'h3fc00000);

    // Reset in the middle of a reduction
    @(negedge clk);
    start = 1'b1; length = 10'd5; bias = 32'h40800000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h3f800000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_acc", out_data, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h3f800000;
      @(negedge clk);
      chk("post_rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    ops[0] = 32'h40000000;
    run(1, 32'h00000000, 0, 0, 1'b0);
    chk("post_rst_sum", out_data, 32'h40000000);

    // Random reductions
    for (int r = 0; r < 25; r++) begin
      int len;
      len = (r % 8 == 7) ? 0 : $urandom_range(1, 12);
      if (r == 20) len = 40;
      for (int i = 0; i < len; i++) ops[i] = rand_fp();
      run(len, rand_fp(), $urandom_range(0, 2), $urandom_range(0, 3), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
